hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers for the MIPS datapath; executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Its hi/lo outputs feed the writeback-result 4:1 select stage, where MFHI/MFLO pick them up.
- busy drives the hazard unit, which stalls any MFHI/MFLO/mul-div issued while the unit is busy.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue strobe, sampled on clk rising edge
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no effect)
- a  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO data)
- b  input  WIDTH  rt operand (multiplier/divisor)
- kill  input  1  abort in-flight operation (exception/flush)
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse: HI/LO just updated by mul/div
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, asynchronous): hi=0, lo=0, busy=0, done=0, counter=0, FSM=IDLE; internal accumulators cleared. Reset mid-operation discards the operation; no done pulse.
- FSM states: IDLE, RUN.
- IDLE, start=1, op in {000..011}, kill=0 at edge E0:
  - Latch |a| and |b| (signed ops) or a and b (unsigned ops); record result signs and op.
  - Go to RUN, busy=1 from E0, counter=0.
- IDLE, start=1, op=100/101: hi or lo <= a at that edge; busy stays 0; done stays 0.
- RUN: one iteration per edge.
  - Multiply: radix-2 shift-add, unsigned 2*WIDTH product.
  - Divide: restoring, unsigned quotient/remainder.
  - Counter increments per edge. At edge E(WIDTH) (E32 by default), after the final iteration:
    - Sign-corrected results are written to hi/lo.
    - busy<=0, done<=1 for exactly one cycle.
    - FSM back to IDLE.
  - busy is high for exactly WIDTH cycles.
- Result mapping:
  - MULT/MULTU: {hi,lo} = 2*WIDTH product.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed product is negated when the operand signs differ.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Boundary cases:
  - Divide by zero (DIV or DIVU): full latency; hi=a (original value), lo={WIDTH{1}}.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (two's-complement wrap); no trap.
  - Operand 0x80000000 in a signed op: magnitude 0x80000000 handled as unsigned WIDTH bits.
- start while busy=1 (any op, including MTHI/MTLO): ignored. The hazard unit guarantees this does not happen; the RTL must still not corrupt state.
- start and kill in the same IDLE cycle: kill wins; nothing is accepted.
- kill during RUN: at the next edge FSM=IDLE, busy=0; hi/lo unchanged; no done.
- kill in IDLE with no start: no effect.
- hi/lo change only on a completion edge, an MTHI/MTLO edge or reset.

Test Plan:
- Reset then MULT a=0xFFFFFFFD (-3), b=7 -> busy high 32 cycles; then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 exactly 32 cycles after start.
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF, done still after 32 cycles.
- MTHI a=0x12345678 then MTLO a=0x9ABCDEF0 in consecutive cycles -> hi/lo update at each edge; busy=0 and no done throughout. Then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULT started, kill asserted on cycle 10 -> busy=0 next cycle; hi/lo retain prior values; no done. Same test with rst_n pulsed low at cycle 10 -> all outputs 0 immediately.
- DIVU a=20, b=3 started; MTLO a=0xDEAD issued with start at cycle 5 -> MTLO ignored; final lo=6, hi=2.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// MULT/DIV take WIDTH cycles (busy high WIDTH cycles, done pulse on completion); MTHI/MTLO update in one edge.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             kill,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_res, neg_rem, div0;
  logic [WIDTH-1:0]   opnd, acc_hi, acc_lo;

  logic               is_signed;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     sum, shifted;
  logic               ge;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;

  assign is_signed = ~op[0];
  assign abs_a = (is_signed && a[WIDTH-1]) ? -a : a;
  assign abs_b = (is_signed && b[WIDTH-1]) ? -b : b;

  // Multiply: {acc_hi,acc_lo} holds partial product over the multiplier.
  // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = shifted >= {1'b0, opnd};
    nxt_hi  = sum[WIDTH:1];
    nxt_lo  = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      nxt_hi = ge ? (shifted[WIDTH-1:0] - opnd) : shifted[WIDTH-1:0];
      nxt_lo = {acc_lo[WIDTH-2:0], ge};
    end
    prod   = {nxt_hi, nxt_lo};
    if (neg_res) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = neg_rem ? -nxt_hi : nxt_hi;
      res_lo = neg_res ? -nxt_lo : nxt_lo;
      if (div0) res_lo = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      opnd    <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !kill) begin
            case (op)
              3'b000, 3'b001, 3'b010, 3'b011: begin
                opnd    <= abs_b;
                acc_hi  <= '0;
                acc_lo  <= abs_a;
                is_div  <= op[1];
                neg_res <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_rem <= is_signed & a[WIDTH-1];
                div0    <= op[1] && (b == '0);
                cnt     <= '0;
                busy    <= 1'b1;
                state   <= RUN;
              end
              3'b100:  hi <= a;
              3'b101:  lo <= a;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (kill) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc_hi <= nxt_hi;
            acc_lo <= nxt_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              hi    <= res_hi;
              lo    <= res_lo;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit with hand-computed HI/LO results.
module tb_hilo_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        kill = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int cyc;
  int dc0;

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges with busy high after the issue edge; expects WIDTH then a done pulse.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    issue(o, x, y);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, 64'(n), 64'd32);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    @(negedge clk);
    chk({tag, "_done_clr"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mult", 3'b000, 32'hFFFFFFFD, 32'd7);
    chk("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    run_op("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
    run_op("div", 3'b010, 32'hFFFFFFF9, 32'd2);
    chk("div_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    run_op("divu0", 3'b011, 32'd100, 32'd0);
    chk("divu0_hilo", {hi, lo}, {32'd100, 32'hFFFFFFFF});

    // start+kill in IDLE and a reserved op must leave everything untouched
    dc0 = done_cnt;
    @(negedge clk);
    op = 3'b100; a = 32'h1; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    op = 3'b110; kill = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("killstart_hilo", {hi, lo}, {32'd100, 32'hFFFFFFFF});
    chk("killstart_busy", {63'd0, busy}, 64'd0);

    @(negedge clk);
    op = 3'b100; a = 32'h12345678; start = 1'b1;
    @(negedge clk);
    chk("mthi_hi", {32'd0, hi}, {32'd0, 32'h12345678});
    chk("mthi_busy", {63'd0, busy}, 64'd0);
    op = 3'b101; a = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_hilo", {hi, lo}, 64'h12345678_9ABCDEF0);
    chk("mtlo_busy", {63'd0, busy}, 64'd0);
    chk("mt_nodone", 64'(done_cnt), 64'(dc0));

    run_op("divovf", 3'b010, 32'h80000000, 32'hFFFFFFFF);
    chk("divovf_hilo", {hi, lo}, 64'h00000000_80000000);
    run_op("divneg", 3'b010, 32'd7, 32'hFFFFFFFE);
    chk("divneg_hilo", {hi, lo}, 64'h00000001_FFFFFFFD);
    run_op("multmin", 3'b000, 32'h80000000, 32'd2);
    chk("multmin_hilo", {hi, lo}, 64'hFFFFFFFF_00000000);

    dc0 = done_cnt;
    issue(3'b000, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    chk("kill_busy_before", {63'd0, busy}, 64'd1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    chk("kill_busy", {63'd0, busy}, 64'd0);
    chk("kill_hilo", {hi, lo}, 64'hFFFFFFFF_00000000);
    repeat (40) @(negedge clk);
    chk("kill_nodone", 64'(done_cnt), 64'(dc0));
    chk("kill_hilo_late", {hi, lo}, 64'hFFFFFFFF_00000000);

    issue(3'b000, 32'd5, 32'd6);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_hilo", {hi, lo}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mrst_nodone", 64'(done_cnt), 64'(dc0));
    chk("mrst_hilo_late", {hi, lo}, 64'd0);

    // MTLO while DIVU is running must be ignored
    issue(3'b011, 32'd20, 32'd3);
    repeat (3) @(negedge clk);
    op = 3'b101; a = 32'h0000DEAD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mtlo_lo", {32'd0, lo}, 64'd0);
    chk("busy_mtlo_busy", {63'd0, busy}, 64'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    chk("divu_cycles_after_mtlo", 64'(cyc), 64'd28);
    chk("divu_hilo", {hi, lo}, {32'd2, 32'd6});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
